// File: rtl/reg_file_wb_pkg.sv
// Shared types and constants for the WB-side register file and its busy scoreboard.
// The optional same-cycle write-to-read bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 6;

    typedef logic [ADDR_W-1:0]   reg_idx_t;
    typedef logic [DATA_W-1:0]   reg_data_t;
    typedef logic [CNT_W-1:0]    busy_cnt_t;
    typedef logic [NUM_REGS-1:0] busy_vec_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

    // Bit 0 of the busy vector is always clear, so the result never exceeds 31.
    function automatic busy_cnt_t count_busy(input busy_vec_t v);
        busy_cnt_t n;
        n = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            n = n + busy_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Bundle of WB write-back, ID read and ID issue signals around the register file.
// The slave side is the register file; the master side is the surrounding pipeline.
interface reg_file_wb_if;
    import regfile_pkg::*;

    logic      RegWrite_WB;
    reg_idx_t  Write_reg_WB;
    reg_data_t Write_data_WB;

    reg_idx_t  Read_reg1_ID;
    reg_idx_t  Read_reg2_ID;
    reg_data_t Read_data1_ID;
    reg_data_t Read_data2_ID;

    logic      Issue_valid_ID;
    reg_idx_t  Issue_dest_ID;

    logic      Busy1_ID;
    logic      Busy2_ID;
    logic      Stall_ID;
    busy_cnt_t Busy_count;

    modport master (
        output RegWrite_WB, Write_reg_WB, Write_data_WB,
        output Read_reg1_ID, Read_reg2_ID,
        output Issue_valid_ID, Issue_dest_ID,
        input  Read_data1_ID, Read_data2_ID,
        input  Busy1_ID, Busy2_ID, Stall_ID, Busy_count
    );

    modport slave (
        input  RegWrite_WB, Write_reg_WB, Write_data_WB,
        input  Read_reg1_ID, Read_reg2_ID,
        input  Issue_valid_ID, Issue_dest_ID,
        output Read_data1_ID, Read_data2_ID,
        output Busy1_ID, Busy2_ID, Stall_ID, Busy_count
    );

endinterface

// File: rtl/reg_file_wb_scoreboard.sv
// Busy scoreboard: ID sets a destination on issue, WB clears it on write-back.
// With REGFILE_BYPASS_EN the read-side busy flags ignore an index being written this cycle.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr_en,
    input  reg_idx_t  clr_idx,
    input  logic      set_en,
    input  reg_idx_t  set_idx,
    input  reg_idx_t  rd1_idx,
    input  reg_idx_t  rd2_idx,
    output logic      busy1,
    output logic      busy2,
    output busy_cnt_t busy_count
);

    busy_vec_t busy;
    busy_vec_t busy_next;
    logic      fwd1;
    logic      fwd2;

    // Set is applied after clear so a newer producer of the same index stays pending.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en && set_idx != ZERO_REG) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_busy(busy_next);
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A write landing this cycle satisfies the reader unless a newer issue reclaims the index.
    assign fwd1 = clr_en && clr_idx == rd1_idx && !(set_en && set_idx == rd1_idx);
    assign fwd2 = clr_en && clr_idx == rd2_idx && !(set_en && set_idx == rd2_idx);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign busy1 = (rd1_idx != ZERO_REG) && busy[rd1_idx] && !fwd1;
    assign busy2 = (rd2_idx != ZERO_REG) && busy[rd2_idx] && !fwd2;

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        busy_count <= busy_cnt_t'(NUM_REGS - 1));

    a_zero_never_busy: assert property (@(posedge clk) disable iff (rst)
        busy[0] == 1'b0);

endmodule

// File: rtl/reg_file_wb.sv
// MIPS GPR file at the MEM/WB boundary: WB writes, ID reads combinationally, scoreboard drives stall.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto the ID read ports.
module reg_file_wb
    import regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    reg_file_wb_if.slave bus
);

    reg_data_t regs [NUM_REGS];
    reg_data_t rd1;
    reg_data_t rd2;
    logic      wr_en;

    assign wr_en = bus.RegWrite_WB && bus.Write_reg_WB != ZERO_REG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.Write_reg_WB] <= bus.Write_data_WB;
        end
    end

    // $0 reads as zero regardless of storage contents or a pending write to it.
    always_comb begin
        rd1 = regs[bus.Read_reg1_ID];
        if (bus.Read_reg1_ID == ZERO_REG) begin
            rd1 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && bus.Write_reg_WB == bus.Read_reg1_ID) begin
            rd1 = bus.Write_data_WB;
        end
`endif
    end

    always_comb begin
        rd2 = regs[bus.Read_reg2_ID];
        if (bus.Read_reg2_ID == ZERO_REG) begin
            rd2 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && bus.Write_reg_WB == bus.Read_reg2_ID) begin
            rd2 = bus.Write_data_WB;
        end
`endif
    end

    assign bus.Read_data1_ID = rd1;
    assign bus.Read_data2_ID = rd2;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clr_en     (bus.RegWrite_WB),
        .clr_idx    (bus.Write_reg_WB),
        .set_en     (bus.Issue_valid_ID),
        .set_idx    (bus.Issue_dest_ID),
        .rd1_idx    (bus.Read_reg1_ID),
        .rd2_idx    (bus.Read_reg2_ID),
        .busy1      (bus.Busy1_ID),
        .busy2      (bus.Busy2_ID),
        .busy_count (bus.Busy_count)
    );

    assign bus.Stall_ID = bus.Busy1_ID | bus.Busy2_ID;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard-driven bench for reg_file_wb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_wb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    exp_t e;
    logic [31:0] model [32];
    int vectors = 0;
    int miscompares = 0;

    reg_file_wb_if bus();

    reg_file_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.RegWrite_WB    = 1'b0;
        bus.Write_reg_WB   = '0;
        bus.Write_data_WB  = '0;
        bus.Issue_valid_ID = 1'b0;
        bus.Issue_dest_ID  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int r, input logic [31:0] d);
        bus.RegWrite_WB   = 1'b1;
        bus.Write_reg_WB  = 5'(r);
        bus.Write_data_WB = d;
        if (r != 0) model[r] = d;
    endtask

    task automatic issue(input int r);
        bus.Issue_valid_ID = 1'b1;
        bus.Issue_dest_ID  = 5'(r);
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_q.push_back('{t, v});
    endtask

    task automatic test_reset();
        bus.Read_reg1_ID = 5'd5;
        bus.Read_reg2_ID = 5'd31;
        push("rst_rd1", 32'h0); push("rst_rd2", 32'h0); push("rst_cnt", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data2_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data2_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end

        next_cycle(); wb(5, 32'hA5A5_5A5A); issue(3);
        next_cycle(); idle();
        bus.Read_reg1_ID = 5'd5;
        bus.Read_reg2_ID = 5'd3;
        push("pre_rst_rd1", model[5]); push("pre_rst_stall", 32'h1); push("pre_rst_cnt", 32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end

        // Mid-cycle reset: no clock edge between asserting rst and sampling.
        #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        push("mid_rst_rd1", 32'h0); push("mid_rst_stall", 32'h0); push("mid_rst_cnt", 32'h0);
        #1;
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        bus.Read_reg1_ID = 5'd5;
        bus.Read_reg2_ID = 5'd0;
        push("wr_same_rd1", BYPASS ? 32'hDEAD_BEEF : model[5]);
        push("wr_same_rd2", 32'h0);
        wb(5, 32'hDEAD_BEEF);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data2_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data2_ID, e.exp); end
        next_cycle(); idle();
        push("wr_next_rd1", model[5]);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        wb(0, 32'hFFFF_FFFF); issue(0);
        bus.Read_reg1_ID = 5'd0;
        bus.Read_reg2_ID = 5'd0;
        push("r0_same_rd1", 32'h0); push("r0_same_stall", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        next_cycle(); idle();
        push("r0_next_rd1", 32'h0); push("r0_next_cnt", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
    endtask

    task automatic test_issue_writeback();
        next_cycle();
        issue(7);
        bus.Read_reg1_ID = 5'd7;
        bus.Read_reg2_ID = 5'd0;
        push("iss_same_stall", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        next_cycle(); idle();
        push("iss_stall", 32'h1); push("iss_cnt", 32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        next_cycle();
        push("wb7_same_stall", BYPASS ? 32'h0 : 32'h1);
        push("wb7_same_rd1", BYPASS ? 32'h1234 : model[7]);
        wb(7, 32'h1234);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        next_cycle(); idle();
        push("wb7_stall", 32'h0); push("wb7_rd1", model[7]); push("wb7_cnt", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
    endtask

    task automatic test_set_clear_same();
        next_cycle();
        issue(9);
        bus.Read_reg1_ID = 5'd9;
        bus.Read_reg2_ID = 5'd10;
        next_cycle();
        wb(9, 32'h99); issue(9);
        push("sc_same_busy1", 32'h1); push("sc_same_cnt", 32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy1_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Busy1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        // Clear 9 and set 10 together: the two indices must update independently.
        next_cycle(); idle();
        push("sc_busy1", BYPASS ? 32'h0 : 32'h1);
        push("sc_cnt", 32'h1);
        push("sc_rd1", BYPASS ? 32'h77 : model[9]);
        wb(9, 32'h77); issue(10);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy1_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Busy1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        next_cycle(); idle();
        push("ind_busy1", 32'h0); push("ind_busy2", 32'h1); push("ind_cnt", 32'h1); push("ind_rd1", model[9]);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy1_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Busy1_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy2_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Busy2_ID, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
        next_cycle();
        wb(10, 32'h10);
        push("wb10_busy2", BYPASS ? 32'h0 : 32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy2_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Busy2_ID, e.exp); end
        next_cycle(); idle();
        push("wb10_cnt", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
    endtask

    task automatic test_fill_drain();
        bus.Read_reg1_ID = 5'd31;
        bus.Read_reg2_ID = 5'd1;
        for (int d = 1; d < 32; d++) begin
            next_cycle(); idle(); issue(d);
            push($sformatf("fill_cnt_%0d", d), 32'(d - 1));
            @(negedge clk);
            e = exp_q.pop_front(); vectors++;
            if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        end
        next_cycle(); idle();
        push("full_cnt", 32'd31); push("full_stall", 32'h1);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        for (int d = 1; d < 32; d++) begin
            next_cycle(); idle(); wb(d, 32'hC000_0000 | 32'(d));
            push($sformatf("drain_cnt_%0d", d), 32'(32 - d));
            @(negedge clk);
            e = exp_q.pop_front(); vectors++;
            if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        end
        next_cycle(); idle(); wb(31, 32'hC000_001F);
        push("empty_cnt", 32'h0); push("empty_stall", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Stall_ID) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %b want %0d", e.tag, bus.Stall_ID, e.exp); end
        next_cycle(); idle();
        push("nowrap_cnt", 32'h0);
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.Busy_count) !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %0d want %0d", e.tag, bus.Busy_count, e.exp); end
    endtask

    task automatic test_readback();
        for (int i = 0; i < 32; i++) begin
            next_cycle(); idle();
            bus.Read_reg1_ID = 5'(i);
            bus.Read_reg2_ID = 5'(31 - i);
            push($sformatf("rb_rd1_%0d", i), model[i]);
            push($sformatf("rb_rd2_%0d", 31 - i), model[31 - i]);
            @(negedge clk);
            e = exp_q.pop_front(); vectors++;
            if (bus.Read_data1_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data1_ID, e.exp); end
            e = exp_q.pop_front(); vectors++;
            if (bus.Read_data2_ID !== e.exp) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", e.tag, bus.Read_data2_ID, e.exp); end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst = 1'b1;
        idle();
        bus.Read_reg1_ID = '0;
        bus.Read_reg2_ID = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_write_read();
        test_zero_reg();
        test_issue_writeback();
        test_set_clear_same();
        test_fill_drain();
        test_readback();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
